// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush bubbles and bubble counter
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       Control_i,
    input  logic [31:0]      RSdata_i,
    input  logic [31:0]      RTdata_i,
    input  logic [31:0]      SignExt_i,
    input  logic [4:0]       RSaddr_i,
    input  logic [4:0]       RTaddr_i,
    input  logic [4:0]       RDaddr_i,
    input  logic [5:0]       Funct_i,
    input  logic             Flush_i,
    output logic             Stall_o,
    output logic [7:0]       Control_o,
    output logic [31:0]      RSdata_o,
    output logic [31:0]      RTdata_o,
    output logic [31:0]      SignExt_o,
    output logic [4:0]       RSaddr_o,
    output logic [4:0]       RTaddr_o,
    output logic [4:0]       WriteReg_o,
    output logic [5:0]       Funct_o,
    output logic [CNT_W-1:0] BubbleCnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic bubble;

    // Hazard uses only the EX copy of MemRead, so a bubble always clears it next cycle
    assign Stall_o = Control_o[2] && (RTaddr_o != 5'd0) &&
                     ((RTaddr_o == RSaddr_i) || (RTaddr_o == RTaddr_i));
    assign bubble  = Flush_i | Stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            Control_o   <= 8'h00;
            RSdata_o    <= 32'd0;
            RTdata_o    <= 32'd0;
            SignExt_o   <= 32'd0;
            RSaddr_o    <= 5'd0;
            RTaddr_o    <= 5'd0;
            WriteReg_o  <= 5'd0;
            Funct_o     <= 6'd0;
            BubbleCnt_o <= '0;
        end else begin
            Control_o  <= bubble ? 8'h00 : Control_i;
            RSdata_o   <= RSdata_i;
            RTdata_o   <= RTdata_i;
            SignExt_o  <= SignExt_i;
            RSaddr_o   <= RSaddr_i;
            RTaddr_o   <= RTaddr_i;
            WriteReg_o <= Control_i[7] ? RDaddr_i : RTaddr_i;
            Funct_o    <= Funct_i;
            if (bubble && (BubbleCnt_o != CNT_MAX)) begin
                BubbleCnt_o <= BubbleCnt_o + 1'b1;
            end
        end
    end

endmodule
